crc32_rx_check: RTL and testbench
=================================

Name: crc32_rx_check

Overview:
- Receive-side CRC-32 checker for 16-bit framed link data.
- Sits behind the link receiver word aligner and in front of the packet decoder.
- Runs the running CRC-32 over the payload words, then compares it against the two trailing CRC words sent by the transmit-side crc32 generator.
- Reports pass/fail and a frame-length error once per frame.

Parameters:
- LEN_W, 10: width of the frame word counter.
- MIN_WORDS, 2: minimum legal frame length in words, CRC words included.
- MAX_WORDS, 512: maximum legal frame length in words, CRC words included.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- d  in  16  received data word.
- d_valid  in  1  d is valid this cycle.
- sof  in  1  qualifies d_valid; word is the first of a frame.
- eof  in  1  qualifies d_valid; word is the last of a frame (second CRC word).
- frame_done  out  1  one-cycle pulse; result flags are updated this cycle.
- crc_ok  out  1  last frame's CRC matched.
- crc_err  out  1  last frame's CRC mismatched.
- len_err  out  1  last frame's length was outside MIN_WORDS..MAX_WORDS.
- word_count  out  LEN_W  words accepted in the current or last frame.
- busy  out  1  a frame is in progress.
- crc_reg  out  32  running CRC register, for debug.

Behaviour:
- Reset values:
  - crc_reg = 0xFFFFFFFF.
  - All flags, frame_done, busy = 0.
  - word_count = 0.
  - Delay line cleared; state = IDLE.
- CRC step:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, 16 bits per step.
  - d[0] is shifted in first; feedback = crc_reg[31] ^ data bit; the register shifts toward the MSB.
  - Must be bit-exact with the transmit crc32 generator's next_crc.
- Two-word delay line w0 (older) / w1 (newer):
  - Each accepted word pushes into w1; w1 moves to w0.
  - Once both are full, the outgoing w0 is fed through the CRC step.
  - The last two words of a frame are therefore never CRC'd; they are the received CRC.
- Expected CRC, from crc_reg after the payload:
  - First CRC word bit i = ~crc_reg[31-i].
  - Second CRC word bit i = ~crc_reg[15-i].
- State machine (transitions only on an accepted word, d_valid=1; d_valid=0 holds everything):
  - IDLE: sof accepted -> crc_reg=0xFFFFFFFF, w1=d, word_count=1, busy=1, go to HOLD1.
    - If eof is also set: 1-word frame, go to IDLE with len_err.
    - A word without sof is ignored.
  - HOLD1: word -> w0=w1, w1=d, go to RUN.
  - RUN: word -> crc_reg=step(crc_reg,w0), w0=w1, w1=d.
- eof accepted in HOLD1 or RUN:
  - Compare {w_older, w_newest} against the expected CRC using crc_reg including any step performed this cycle.
  - Length check uses the count including the eof word.
  - Next cycle: frame_done=1; exactly one of crc_ok/crc_err is 1; len_err is set if count < MIN_WORDS or > MAX_WORDS; busy=0; state=IDLE.
  - Latency: 1 cycle from the eof word to the flags.
- 1-word frame (sof&eof in IDLE): frame_done=1, len_err=1, crc_err=1, crc_ok=0.
- Flags are sticky until the next sof is accepted (cleared in that same cycle) or reset.
- word_count:
  - Increments per accepted word in frame and saturates at 2^LEN_W-1.
  - Saturation implies len_err at eof when MAX_WORDS < 2^LEN_W-1.
  - Holds its value after eof.
- sof accepted while in HOLD1/RUN: the current frame is abandoned silently (no frame_done) and a new frame starts as from IDLE.
- sof&eof on the same word in HOLD1/RUN: abandon, then treat as a 1-word frame.
- Reset mid-frame: immediate return to reset values; no frame_done.

Decomposition:
- Shared package crc32_pkg:
  - CRC32_INIT = 32'hFFFFFFFF.
  - CRC32_POLY = 32'h04C11DB7.
  - function crc32_d16_next(crc, d), used by both transmit generator and checker.
  - function crc32_tx_word(crc, hi), giving the transmitted CRC word format.
  - State enum {IDLE, HOLD1, RUN}.
- One natural sub-module: crc32_d16_step, a combinational next-CRC wrapper instanced once.

Test Plan:
- Frame {0x0000 sof, 0x0000 eof} (empty payload, CRC of 0xFFFFFFFF) -> next cycle frame_done=1, crc_ok=1, crc_err=0, len_err=0, word_count=2.
- Frame {0x0000 sof, 0x0001 eof} -> frame_done=1, crc_err=1, crc_ok=0.
- Payload 0x1234,0x5678,0xABCD plus 2 CRC words from the transmit generator, with d_valid gaps of 0-3 cycles -> crc_ok=1, word_count=5; crc_reg matches the golden model after each payload word.
- Single word 0xAAAA with sof&eof -> frame_done=1, len_err=1, crc_err=1.
- sof mid-frame after 3 words, then a good 2-word empty frame -> no frame_done for the aborted frame; one frame_done with crc_ok=1, word_count=2.
- Good frame of MAX_WORDS+1=513 words -> crc_ok=1, len_err=1.
- Assert reset in RUN -> all outputs zero, crc_reg=0xFFFFFFFF, busy=0, no frame_done.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the 16-bit link: constants, checker states and the
// per-word next-CRC / transmitted-word helpers used by both generator and checker.
package crc32_pkg;

    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE,
        HOLD1,
        RUN
    } state_t;

    // d[0] enters first; the register shifts toward the MSB.
    function automatic logic [31:0] crc32_d16_next(input logic [31:0] crc, input logic [15:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ ({32{fb}} & CRC32_POLY);
        end
        return c;
    endfunction

    // hi=1 gives the first transmitted CRC word, hi=0 the second.
    function automatic logic [15:0] crc32_tx_word(input logic [31:0] crc, input logic hi);
        logic [15:0] w;
        for (int unsigned i = 0; i < 16; i++) begin
            w[i] = hi ? ~crc[31-i] : ~crc[15-i];
        end
        return w;
    endfunction

endpackage

// File: rtl/crc32_rx_check_step.sv
// Combinational one-word CRC-32 update, shared algorithm with the transmit generator.
module crc32_d16_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [15:0] d,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc32_d16_next(crc_in, d);
    end

endmodule

// File: rtl/crc32_rx_check.sv
// Receive-side CRC-32 checker: CRCs the payload through a two-word delay line and
// compares the final two words of each frame against the expected CRC.
module crc32_rx_check
    import crc32_pkg::*;
#(
    parameter int unsigned LEN_W     = 10,
    parameter int unsigned MIN_WORDS = 2,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      d,
    input  logic             d_valid,
    input  logic             sof,
    input  logic             eof,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic [LEN_W-1:0] word_count,
    output logic             busy,
    output logic [31:0]      crc_reg
);

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [15:0]        w0_q, w0_d;
    logic [15:0]        w1_q, w1_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               len_q, len_d;

    logic [31:0]        crc_step;
    logic [31:0]        crc_use;
    logic [LEN_W-1:0]   cnt_inc;
    logic               good;
    logic               len_bad;

    crc32_d16_step u_step (
        .crc_in  (crc_q),
        .d       (w0_q),
        .crc_out (crc_step)
    );

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        len_d   = len_q;

        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // In RUN the outgoing w0 is CRC'd this cycle, so compare against the stepped value.
        crc_use = (state_q == RUN) ? crc_step : crc_q;
        good    = (w1_q == crc32_tx_word(crc_use, 1'b1)) &&
                  (d    == crc32_tx_word(crc_use, 1'b0));
        len_bad = (32'(cnt_inc) < MIN_WORDS) || (32'(cnt_inc) > MAX_WORDS);

        if (d_valid) begin
            if (sof) begin
                state_d = HOLD1;
                crc_d   = CRC32_INIT;
                w1_d    = d;
                cnt_d   = {{(LEN_W-1){1'b0}}, 1'b1};
                busy_d  = 1'b1;
                ok_d    = 1'b0;
                err_d   = 1'b0;
                len_d   = 1'b0;
                if (eof) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    len_d   = 1'b1;
                end
            end else if (state_q != IDLE) begin
                state_d = RUN;
                crc_d   = crc_use;
                w0_d    = w1_q;
                w1_d    = d;
                cnt_d   = cnt_inc;
                if (eof) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ok_d    = good;
                    err_d   = !good;
                    len_d   = len_bad;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            w0_q    <= '0;
            w1_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign crc_err    = err_q;
    assign len_err    = len_q;
    assign word_count = cnt_q;
    assign busy       = busy_q;
    assign crc_reg    = crc_q;

endmodule

// File: tb/tb_crc32_rx_check.sv
// Directed bench for crc32_rx_check: table of frames plus hand-written abort,
// length-boundary and mid-frame reset sequences, checked against a local CRC model.
module tb_crc32_rx_check;

    localparam int unsigned LEN_W = 10;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] INIT  = 32'hFFFFFFFF;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      d;
    logic             d_valid, sof, eof;
    logic             frame_done, crc_ok, crc_err, len_err, busy;
    logic [LEN_W-1:0] word_count;
    logic [31:0]      crc_reg;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;
    logic [15:0] fw[$];

    always #5 clk = ~clk;

    crc32_rx_check #(.LEN_W(10), .MIN_WORDS(2), .MAX_WORDS(512)) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .d_valid    (d_valid),
        .sof        (sof),
        .eof        (eof),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .len_err    (len_err),
        .word_count (word_count),
        .busy       (busy),
        .crc_reg    (crc_reg)
    );

    always @(negedge clk) if (frame_done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] m_step(input logic [31:0] c, input logic [15:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 16; b++) begin
            if (r[31] != w[b]) r = (r << 1) ^ POLY;
            else               r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] m_word(input logic [31:0] c, input bit hi);
        logic [15:0] o;
        for (int i = 0; i < 16; i++) o[i] = hi ? !c[31-i] : !c[15-i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w, input bit s, input bit e);
        d = w; d_valid = 1'b1; sof = s; eof = e;
        tick();
        d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    endtask

    // Sends fw as one frame with random idle gaps and checks crc_reg per word and the result.
    task automatic run_frame(input string tag, input bit e_ok, input bit e_err, input bit e_len,
                             input int unsigned e_cnt, input int unsigned maxgap);
        logic [31:0] mc;
        int unsigned d0;
        mc = INIT;
        d0 = done_cnt;
        for (int j = 0; j < fw.size(); j++) begin
            send(fw[j], j == 0, j == fw.size() - 1);
            if (j >= 2) mc = m_step(mc, fw[j-2]);
            if (fw.size() < 20 || j % 64 == 0 || j >= fw.size() - 3)
                chk($sformatf("%s crc_reg w%0d", tag, j), crc_reg, mc);
            if (j != fw.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
        end
        chk({tag, " frame_done"}, 32'(frame_done), 32'd1);
        chk({tag, " crc_ok"},     32'(crc_ok),     32'(e_ok));
        chk({tag, " crc_err"},    32'(crc_err),    32'(e_err));
        chk({tag, " len_err"},    32'(len_err),    32'(e_len));
        chk({tag, " word_count"}, 32'(word_count), e_cnt);
        chk({tag, " busy"},       32'(busy),       32'd0);
        tick();
        chk({tag, " pulse ends"}, 32'(frame_done), 32'd0);
        chk({tag, " sticky ok"},  32'(crc_ok),     32'(e_ok));
        chk({tag, " done count"}, done_cnt - d0,   32'd1);
    endtask

    task automatic add_crc(input logic [15:0] flip);
        logic [31:0] c;
        c = INIT;
        for (int j = 0; j < fw.size(); j++) c = m_step(c, fw[j]);
        fw.push_back(m_word(c, 1'b1));
        fw.push_back(m_word(c, 1'b0) ^ flip);
    endtask

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        int unsigned npl;
        bit          crc;
        logic [15:0] flip;
        int unsigned gap;
        bit          e_ok, e_err, e_len;
        int unsigned e_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int unsigned d0;
        logic [15:0] pl[4];

        reset = 1'b1; d = '0; d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        repeat (3) tick();
        chk("reset crc_reg",    crc_reg,          INIT);
        chk("reset frame_done", 32'(frame_done),  32'd0);
        chk("reset flags",      {29'd0, crc_ok, crc_err, len_err}, 32'd0);
        chk("reset word_count", 32'(word_count),  32'd0);
        chk("reset busy",       32'(busy),        32'd0);
        reset = 1'b0;
        tick();

        // p0..p3, npl, append CRC, flip mask on 2nd CRC word, max gap, ok, err, len, count
        tbl[0] = '{16'h0000, 16'h0000, 16'h0, 16'h0, 2, 0, 16'h0,    0, 1, 0, 0, 2};
        tbl[1] = '{16'h0000, 16'h0001, 16'h0, 16'h0, 2, 0, 16'h0,    0, 0, 1, 0, 2};
        tbl[2] = '{16'h1234, 16'h5678, 16'hABCD, 16'h0, 3, 1, 16'h0, 3, 1, 0, 0, 5};
        tbl[3] = '{16'hAAAA, 16'h0000, 16'h0, 16'h0, 1, 0, 16'h0,    0, 0, 1, 1, 1};
        tbl[4] = '{16'h1234, 16'h0000, 16'h0, 16'h0, 1, 1, 16'h0100, 1, 0, 1, 0, 3};
        tbl[5] = '{16'hCAFE, 16'hBEEF, 16'h0001, 16'h8000, 4, 1, 16'h0, 2, 1, 0, 0, 6};

        for (int v = 0; v < 6; v++) begin
            pl[0] = tbl[v].p0; pl[1] = tbl[v].p1; pl[2] = tbl[v].p2; pl[3] = tbl[v].p3;
            fw.delete();
            for (int k = 0; k < int'(tbl[v].npl); k++) fw.push_back(pl[k]);
            if (tbl[v].crc) add_crc(tbl[v].flip);
            run_frame($sformatf("vec%0d", v), tbl[v].e_ok, tbl[v].e_err, tbl[v].e_len,
                      tbl[v].e_cnt, tbl[v].gap);
            repeat (2) tick();
        end

        // Abandoned frame followed by a good empty frame; sof also clears sticky flags.
        d0 = done_cnt;
        send(16'h1111, 1'b1, 1'b0);
        chk("abort sof clears ok", 32'(crc_ok),     32'd0);
        chk("abort busy",          32'(busy),       32'd1);
        chk("abort count1",        32'(word_count), 32'd1);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0);
        chk("abort count3",        32'(word_count), 32'd3);
        fw.delete();
        fw.push_back(16'h0000); fw.push_back(16'h0000);
        run_frame("abort_restart", 1'b1, 1'b0, 1'b0, 2, 0);
        chk("abort total done", done_cnt - d0, 32'd1);

        // Length boundary: 512 words is legal, 513 is not.
        fw.delete();
        for (int k = 0; k < 510; k++) fw.push_back(16'(k * 16'h0101 + 16'h5A));
        add_crc(16'h0);
        run_frame("len512", 1'b1, 1'b0, 1'b0, 512, 0);
        fw.delete();
        for (int k = 0; k < 511; k++) fw.push_back(16'(k * 16'h0307 + 16'h11));
        add_crc(16'h0);
        run_frame("len513", 1'b1, 1'b0, 1'b1, 513, 0);

        // Reset asserted while in RUN.
        d0 = done_cnt;
        send(16'h1111, 1'b1, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0);
        chk("pre-reset crc stepped", crc_reg, m_step(INIT, 16'h1111));
        #2 reset = 1'b1;
        #1;
        chk("midreset crc_reg",    crc_reg,         INIT);
        chk("midreset busy",       32'(busy),       32'd0);
        chk("midreset word_count", 32'(word_count), 32'd0);
        chk("midreset flags",      {28'd0, frame_done, crc_ok, crc_err, len_err}, 32'd0);
        tick();
        reset = 1'b0;
        send(16'h5555, 1'b0, 1'b1);
        chk("post-reset no-sof ignored busy",  32'(busy),       32'd0);
        chk("post-reset no-sof ignored count", 32'(word_count), 32'd0);
        tick();
        chk("reset no frame_done", done_cnt - d0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
